// File: rtl/bpsk_rxd_demod_if.sv
// Sample-in / bit-out bundle for the BPSK receive demodulator.
// master: sample source and bit consumer; slave: the demodulator.
interface bpsk_rxd_demod_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] rxd_sig;
    logic                     sample_vld;
    logic                     bit_out;
    logic                     bit_vld;
    logic                     lock;
    logic                     inv_flag;

    modport master (
        output rxd_sig, sample_vld,
        input  bit_out, bit_vld, lock, inv_flag
    );

    modport slave (
        input  rxd_sig, sample_vld,
        output bit_out, bit_vld, lock, inv_flag
    );
endinterface

// File: rtl/bpsk_rxd_demod.sv
// BPSK receive demodulator: integrate-and-dump against a square-wave carrier
// reference, hard decisions, sync-word hunt with 180-degree ambiguity
// resolution, and payload delivery with a one-cycle valid strobe.
// Optional build macro BPSK_RXD_DIFF_DECODE_EN selects differential (DBPSK)
// decoding; with it undefined, decisions are coherent and inverted-sync
// matches are corrected through inv_flag.
module bpsk_rxd_demod #(
    parameter int                 DATA_W    = 16,
    parameter int                 SPB       = 20,
    parameter int                 ACC_W     = 24,
    parameter int                 ENERGY_TH = 1024,
    parameter int                 SYNC_W    = 8,
    parameter logic [SYNC_W-1:0]  SYNC_WORD = 8'hD3,
    parameter int                 HUNT_BITS = 64,
    parameter int                 WEAK_TH   = 4096,
    parameter int                 LOSS_BITS = 4
) (
    input  logic              clk_sig,
    input  logic              rst,
    bpsk_rxd_demod_if.slave   bus
);
    localparam int CNT_W = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int HNT_W = $clog2(HUNT_BITS + 1);
    localparam int WK_W  = $clog2(LOSS_BITS + 1);

    localparam logic [DATA_W-1:0]       S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]       E_TH  = DATA_W'(ENERGY_TH);
    localparam logic signed [ACC_W-1:0] W_TH  = ACC_W'(WEAK_TH);

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SYNC_W-1:0]        sr_q, sr_d;
    logic [HNT_W-1:0]         hunt_q, hunt_d;
    logic [WK_W-1:0]          weak_q, weak_d;
    logic                     inv_q, inv_d;
    logic                     bit_out_q, bit_out_d;
    logic                     bit_vld_q, bit_vld_d;

    logic [DATA_W-1:0]        mag;
    logic signed [ACC_W-1:0]  smp_x, contrib, sum;
    logic                     bit_end, d_raw, d_out, weak_bit, inv_hit;
    logic [SYNC_W-1:0]        sr_nxt;

`ifdef BPSK_RXD_DIFF_DECODE_EN
    logic                     prev_q, prev_d;
    // Differential decode: phase ambiguity cancels, so inverted sync never sets inv_flag
    assign d_out   = d_raw ^ prev_q;
    assign inv_hit = 1'b0;
`else
    assign d_out   = d_raw ^ inv_q;
    assign inv_hit = 1'b1;
`endif

    // Sample magnitude for the energy test; the most negative code saturates
    always_comb begin
        mag = bus.rxd_sig;
        if (bus.rxd_sig[DATA_W-1])
            mag = (bus.rxd_sig == S_MIN) ? ~S_MIN : (~bus.rxd_sig + 1'b1);
    end

    assign smp_x    = {{(ACC_W-DATA_W){bus.rxd_sig[DATA_W-1]}}, bus.rxd_sig};
    assign contrib  = (cnt_q < CNT_W'(SPB/2)) ? smp_x : -smp_x;
    assign sum      = acc_q + contrib;
    assign bit_end  = (cnt_q == CNT_W'(SPB-1));
    assign d_raw    = ~sum[ACC_W-1];
    assign weak_bit = (sum < W_TH) && (sum > -W_TH);
    assign sr_nxt   = {sr_q[SYNC_W-2:0], d_raw};

    // Next-state: acquisition, integration, sync hunt, locked delivery and loss
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        hunt_d    = hunt_q;
        weak_d    = weak_q;
        inv_d     = inv_q;
        bit_out_d = bit_out_q;
        bit_vld_d = 1'b0;
`ifdef BPSK_RXD_DIFF_DECODE_EN
        prev_d    = prev_q;
`endif
        if (bus.sample_vld) begin
            case (state_q)
                IDLE: begin
                    // First energetic sample is count 0 of the first bit
                    if (mag >= E_TH) begin
                        state_d = HUNT;
                        acc_d   = contrib;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    if (!bit_end) begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        acc_d = '0;
                        cnt_d = '0;
`ifdef BPSK_RXD_DIFF_DECODE_EN
                        // Tracking every raw decision leaves the last sync bit here at lock entry
                        prev_d = d_raw;
`endif
                        if (state_q == HUNT) begin
                            sr_d = sr_nxt;
                            if (sr_nxt == SYNC_WORD) begin
                                state_d = LOCKED;
                                inv_d   = 1'b0;
                                hunt_d  = '0;
                                weak_d  = '0;
                            end else if (sr_nxt == ~SYNC_WORD) begin
                                state_d = LOCKED;
                                inv_d   = inv_hit;
                                hunt_d  = '0;
                                weak_d  = '0;
                            end else if (hunt_q == HNT_W'(HUNT_BITS-1)) begin
                                state_d = IDLE;
                                sr_d    = '0;
                                hunt_d  = '0;
                            end else begin
                                hunt_d = hunt_q + 1'b1;
                            end
                        end else begin
                            bit_out_d = d_out;
                            bit_vld_d = 1'b1;
                            if (!weak_bit) begin
                                weak_d = '0;
                            end else if (weak_q == WK_W'(LOSS_BITS-1)) begin
                                state_d = IDLE;
                                inv_d   = 1'b0;
                                weak_d  = '0;
                                sr_d    = '0;
                            end else begin
                                weak_d = weak_q + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_sig) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath, counters and output registers
    always_ff @(posedge clk_sig) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            hunt_q    <= '0;
            weak_q    <= '0;
            inv_q     <= 1'b0;
            bit_out_q <= 1'b0;
            bit_vld_q <= 1'b0;
`ifdef BPSK_RXD_DIFF_DECODE_EN
            prev_q    <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            hunt_q    <= hunt_d;
            weak_q    <= weak_d;
            inv_q     <= inv_d;
            bit_out_q <= bit_out_d;
            bit_vld_q <= bit_vld_d;
`ifdef BPSK_RXD_DIFF_DECODE_EN
            prev_q    <= prev_d;
`endif
        end
    end

    assign bus.bit_out  = bit_out_q;
    assign bus.bit_vld  = bit_vld_q;
    assign bus.lock     = (state_q == LOCKED);
    assign bus.inv_flag = inv_q;
endmodule

// File: doc/bpsk_rxd_demod.md
Name: bpsk_rxd_demod

Overview:
- Receive-side stage directly downstream of the BPSK transmitter.
- Consumes the 16-bit signed BPSK sample stream produced by txd (txd_sig) at the fast sample clock.
- Correlates the stream against a square-wave carrier reference with integrate-and-dump over each bit period, then makes hard bit decisions.
- Hunts for a sync word, resolves the 180° BPSK phase ambiguity, and delivers payload bits with a valid strobe.

Parameters:
- DATA_W, 16, input sample width (signed two's complement).
- SPB, 20, samples per bit; also the carrier period in samples (400 MHz / 20 MHz). Must be even.
- ACC_W, 24, accumulator width. Must be >= DATA_W + ceil(log2(SPB)) + 1.
- ENERGY_TH, 1024, minimum |sample| that starts acquisition.
- SYNC_W, 8, sync word length in bits.
- SYNC_WORD, 8'hD3, sync pattern, first-received bit in the MSB.
- HUNT_BITS, 64, decided bits allowed in HUNT before giving up.
- WEAK_TH, 4096, |bit correlation| below this counts as a weak bit.
- LOSS_BITS, 4, consecutive weak bits that drop lock.

Ports:
- clk_sig  in  1  single clock; sample clock domain.
- rst  in  1  synchronous, active-high reset.
- rxd_sig  in  DATA_W  signed sample from txd.
- sample_vld  in  1  rxd_sig is valid this cycle.
- bit_out  out  1  decided payload bit.
- bit_vld  out  1  one-cycle strobe qualifying bit_out.
- lock  out  1  sync word found, payload being delivered.
- inv_flag  out  1  inverted sync word matched; decisions are being complemented.

Behaviour:
- Reset (rst high at a clk_sig edge): state=IDLE; acc=0; sample count=0; sync shift register=0; hunt and weak counters=0. Outputs: bit_out=0, bit_vld=0, lock=0, inv_flag=0. Reset mid-frame discards the partial bit and any lock.
- sample_vld low: all state, counters and accumulator hold; bit_vld=0.
- Reference sign: +1 for count < SPB/2, -1 otherwise. Contribution = ±rxd_sig, sign-extended to ACC_W.
- |x| for the energy test: -2^(DATA_W-1) is treated as 2^(DATA_W-1)-1.
- IDLE:
  - On a valid sample with |rxd_sig| >= ENERGY_TH, go to HUNT. That sample is count 0 of the first bit and is accumulated.
  - Otherwise no accumulation.
- Integration (HUNT and LOCKED):
  - Each valid sample: acc += contribution; count increments.
  - At count == SPB-1, sum = acc + contribution. Decision d = (sum >= 0), XOR inv_flag when in LOCKED. acc and count clear on the same edge. A sum of exactly 0 decides 1.
- HUNT:
  - Each decision shifts into the SYNC_W-bit shift register, LSB-in.
  - Shift register == SYNC_WORD → LOCKED, inv_flag=0.
  - Shift register == ~SYNC_WORD → LOCKED, inv_flag=1.
  - Otherwise hunt counter increments; when it reaches HUNT_BITS, return to IDLE.
  - Matching is checked after every decided bit, including the first SYNC_W-1 (shift register reset is 0).
  - No bit_vld in HUNT. lock rises on the edge that registers the matching bit.
- LOCKED:
  - Every decision drives bit_out=d and bit_vld=1 for exactly one cycle. Latency: bit_vld is high in the cycle after the last sample of the bit is presented.
  - |sum| < WEAK_TH increments the weak counter; any strong bit clears it.
  - When the weak counter reaches LOSS_BITS, go to IDLE, clear lock and inv_flag. The bit that triggers the loss is still output (bit_vld=1 that cycle).
- No back-pressure; downstream must accept every bit_vld.

Optional Feature:
- Macro: BPSK_RXD_DIFF_DECODE_EN.
- Defined: differential (DBPSK) decoding. Output bit = d XOR previous raw decision; previous raw decision register resets to 0 and is reloaded at lock entry from the last sync bit. inv_flag is forced to 0 because the ambiguity cancels. The ~SYNC_WORD match still locks.
- Undefined: coherent decisions with inv_flag correction, as described in Behaviour.

Test Plan:
- Reset, then 200 samples of 0 with sample_vld=1 → stays IDLE; lock=0, bit_vld never asserted.
- Clean txd stream (amplitude ±8000 square carrier), sync D3 followed by payload A5 → lock rises after the 8th bit; 8 bit_vld pulses carry 1,0,1,0,0,1,0,1; inv_flag=0.
- Same stream negated → lock, inv_flag=1, payload still reads A5.
- sample_vld toggled 1/0 every cycle during a frame → identical bits, bit spacing doubled to 40 clocks.
- After lock, drive 4 bits of amplitude ±100 → 4th weak bit output with bit_vld, then lock=0, state IDLE; with 3 weak bits then 1 strong bit → lock held.
- Assert rst for one cycle mid-payload → all outputs 0 next cycle; no bit_vld until a new sync match.
